// File: rtl/fns_cac_encoder_pipe.sv
// Pipelined Fibonacci-numeral-system crosstalk-avoidance encoder with
// valid/ready flow control, out-of-range flagging and a saturating error count.

package fns_cac_encoder_pipe_pkg;

  // Fibonacci number with fib(0)=0, fib(1)=fib(2)=1
  function automatic logic [63:0] fib(input int unsigned n);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd0;
    b = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

endpackage

module fns_cac_encoder_pipe
  import fns_cac_encoder_pipe_pkg::*;
#(
  parameter int unsigned CODE_W      = 27,
  parameter int unsigned PIPE_STAGES = 3,
  parameter int unsigned ERRCNT_W    = 16,
  localparam int unsigned DATA_W     = $clog2(fib(CODE_W + 2))
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CODE_W-1:0]   out_code,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ERRCNT_W-1:0] err_count,
  input  logic                err_clr
);

  localparam logic [63:0] LIMIT = fib(CODE_W + 2);
  localparam int unsigned CHAIN = CODE_W - 1;
  localparam int unsigned BASE  = CHAIN / PIPE_STAGES;
  localparam int unsigned REM   = CHAIN % PIPE_STAGES;
  localparam int unsigned SPLIT = REM * (BASE + 1);
  localparam int unsigned WIW   = $clog2(CODE_W + 1);
  localparam int unsigned CIW   = $clog2(CODE_W);

  // W(k) = fib(k+1) for k = 0..CODE_W; W(CODE_W) is only ever compared against
  typedef logic [63:0] wt_t [CODE_W+1];

  function automatic wt_t gen_wt();
    wt_t w;
    for (int unsigned k = 0; k <= CODE_W; k++) w[k] = fib(k + 1);
    return w;
  endfunction

  localparam wt_t WT = gen_wt();

  typedef struct packed {
    logic              v;
    logic              e;
    logic [DATA_W-1:0] r;
    logic [CODE_W-1:0] c;
    logic              l;
  } stage_t;

  // Chain position i (bit CODE_W-1-i) to owning stage; earlier stages take the extra bit
  function automatic int unsigned stage_of(input int unsigned i);
    if (i < SPLIT) return i / (BASE + 1);
    return REM + (i - SPLIT) / BASE;
  endfunction

  // Decide this stage's slice of bits; the last stage also fills c[0] and applies the error mask
  function automatic stage_t step(input stage_t src, input int unsigned s);
    stage_t           o;
    logic [63:0]      rx;
    logic             d;
    logic [WIW-1:0]   kw;
    logic [CIW-1:0]   kc;
    o = src;
    for (int unsigned i = 0; i < CHAIN; i++) begin
      if (stage_of(i) == s) begin
        kw = WIW'(CODE_W - 1 - i);
        kc = CIW'(CODE_W - 1 - i);
        rx = {{(64-DATA_W){1'b0}}, o.r};
        if (rx < WT[kw])              d = 1'b0;
        else if (rx >= WT[kw + 1'b1]) d = 1'b1;
        else                          d = o.l;
        o.c[kc] = d;
        o.l     = d;
        if (d) o.r = o.r - WT[kw][DATA_W-1:0];
      end
    end
    if (s == PIPE_STAGES - 1) begin
      o.c[0] = o.r[0];
      if (o.e) o.c = '0;
    end
    return o;
  endfunction

  stage_t st [PIPE_STAGES];
  stage_t nx [PIPE_STAGES];
  stage_t head;
  logic   advance;
  logic   in_err;
  logic   unused_tail;

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign in_err    = ({{(64-DATA_W){1'b0}}, in_data} >= LIMIT);
  assign out_valid = st[PIPE_STAGES-1].v;
  assign out_err   = st[PIPE_STAGES-1].e;
  assign out_code  = st[PIPE_STAGES-1].c;
  assign unused_tail = ^{st[PIPE_STAGES-1].r, st[PIPE_STAGES-1].l};

  // Next-state of every stage register from its predecessor
  always_comb begin
    head.v = in_valid & advance;
    head.e = in_err;
    head.r = in_data;
    head.c = '0;
    head.l = 1'b0;
    nx[0] = step(head, 0);
    for (int unsigned s = 1; s < PIPE_STAGES; s++) nx[s] = step(st[s-1], s);
  end

  // Pipeline registers: whole pipe advances or holds together
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < PIPE_STAGES; s++) st[s] <= '0;
    end else if (advance) begin
      for (int unsigned s = 0; s < PIPE_STAGES; s++) st[s] <= nx[s];
    end
  end

  // Saturating count of accepted out-of-range words; clear wins over increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                                 err_count <= '0;
    else if (err_clr)                                             err_count <= '0;
    else if (in_valid && in_ready && in_err && (err_count != '1)) err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_fns_cac_encoder_pipe.sv
// Scoreboard bench for fns_cac_encoder_pipe: three configurations
// (CODE_W=4/PS=1, CODE_W=27/PS=3 with 2-bit error counter, CODE_W=10/PS=4).

module tb_fns_cac_encoder_pipe;

  typedef struct {
    logic [39:0] code;
    logic        err;
    int          cyc;
    logic        lat;
    int          val;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic c_rand = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  logic [2:0]  a_in_data;  logic a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready, a_err_clr;
  logic [3:0]  a_out_code; logic [15:0] a_err_count;
  logic [18:0] b_in_data;  logic b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready, b_err_clr;
  logic [26:0] b_out_code; logic [1:0]  b_err_count;
  logic [7:0]  c_in_data;  logic c_in_valid, c_in_ready, c_out_err, c_out_valid, c_out_ready, c_err_clr;
  logic [9:0]  c_out_code; logic [15:0] c_err_count;

  fns_cac_encoder_pipe #(.CODE_W(4), .PIPE_STAGES(1)) u_a (
    .clock(clock), .reset_n(reset_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_code(a_out_code), .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .err_count(a_err_count), .err_clr(a_err_clr));

  fns_cac_encoder_pipe #(.CODE_W(27), .PIPE_STAGES(3), .ERRCNT_W(2)) u_b (
    .clock(clock), .reset_n(reset_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_code(b_out_code), .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .err_count(b_err_count), .err_clr(b_err_clr));

  fns_cac_encoder_pipe #(.CODE_W(10), .PIPE_STAGES(4)) u_c (
    .clock(clock), .reset_n(reset_n), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_code(c_out_code), .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .err_count(c_err_count), .err_clr(c_err_clr));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: in_ready never asserted within bound", name);
  endtask

  function automatic int tbw(input int k);
    int a, b, t;
    a = 1; b = 1;
    for (int i = 1; i < k; i++) begin
      t = a + b; a = b; b = t;
    end
    return b;
  endfunction

  function automatic int decode(input logic [39:0] c, input int w);
    int s;
    s = 0;
    for (int k = 0; k < w; k++) if (c[k]) s += tbw(k);
    return s;
  endfunction

  task automatic send_a(input logic [2:0] d, input logic [3:0] c);
    int   n;
    exp_t t;
    n = 0;
    a_in_data = d; a_in_valid = 1'b1;
    while (!a_in_ready && n < 200) begin @(negedge clock); n++; end
    if (!a_in_ready) timeout("a_send");
    else begin
      t.code = 40'(c); t.err = 1'b0; t.cyc = cyc; t.lat = 1'b1; t.val = 0;
      qa.push_back(t);
    end
    @(negedge clock);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [18:0] d, input logic [26:0] c, input logic e, input logic lat);
    int   n;
    exp_t t;
    n = 0;
    b_in_data = d; b_in_valid = 1'b1;
    while (!b_in_ready && n < 200) begin @(negedge clock); n++; end
    if (!b_in_ready) timeout("b_send");
    else begin
      t.code = 40'(c); t.err = e; t.cyc = cyc; t.lat = lat; t.val = 0;
      qb.push_back(t);
    end
    @(negedge clock);
    b_in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] d);
    int   n;
    exp_t t;
    n = 0;
    c_in_data = d; c_in_valid = 1'b1;
    while (!c_in_ready && n < 200) begin @(negedge clock); n++; end
    if (!c_in_ready) timeout("c_send");
    else begin
      t.code = '0; t.err = (d >= 8'd144); t.cyc = cyc; t.lat = 1'b0; t.val = int'(d);
      qc.push_back(t);
    end
    @(negedge clock);
    c_in_valid = 1'b0;
  endtask

  // Monitor A
  always @(negedge clock) begin
    if (reset_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_extra: unexpected output code %h, expected none", a_out_code);
      end else begin
        ea = qa.pop_front();
        tk("a_code", 64'(a_out_code), 64'(ea.code));
        tk("a_err", 64'(a_out_err), 64'(ea.err));
        if (ea.lat) tk("a_latency", 64'(cyc - ea.cyc), 64'd1);
      end
    end
  end

  // Monitor B
  always @(negedge clock) begin
    if (reset_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_extra: unexpected output code %h, expected none", b_out_code);
      end else begin
        eb = qb.pop_front();
        tk("b_code", 64'(b_out_code), 64'(eb.code));
        tk("b_err", 64'(b_out_err), 64'(eb.err));
        if (eb.lat) tk("b_latency", 64'(cyc - eb.cyc), 64'd3);
      end
    end
  end

  // Monitor C: codewords must decode back to the input, in order
  always @(negedge clock) begin
    if (reset_n && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL c_extra: unexpected output code %h, expected none", c_out_code);
      end else begin
        ec = qc.pop_front();
        tk("c_err", 64'(c_out_err), 64'(ec.err));
        if (ec.err) tk("c_code_err", 64'(c_out_code), 64'd0);
        else        tk("c_decode", 64'(decode(40'(c_out_code), 10)), 64'(ec.val));
      end
    end
  end

  // Random backpressure for C, changed just after the active edge
  initial begin
    c_out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      c_out_ready = c_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    int n;
    reset_n = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_err_clr = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_err_clr = 1'b0;
    c_in_data = '0; c_in_valid = 1'b0; c_err_clr = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tk("rst_a_valid", 64'(a_out_valid), 64'd0);
    tk("rst_b_valid", 64'(b_out_valid), 64'd0);
    tk("rst_b_code", 64'(b_out_code), 64'd0);
    tk("rst_b_err", 64'(b_out_err), 64'd0);
    tk("rst_b_cnt", 64'(b_err_count), 64'd0);
    tk("rst_b_ready", 64'(b_in_ready), 64'd1);
    tk("rst_c_valid", 64'(c_out_valid), 64'd0);

    // CODE_W=4 back-to-back
    send_a(3'd0, 4'h0); send_a(3'd3, 4'h6); send_a(3'd4, 4'h7);
    send_a(3'd5, 4'hC); send_a(3'd6, 4'hE); send_a(3'd7, 4'hF);
    send_a(3'd2, 4'h3);
    repeat (3) @(negedge clock);
    tk("a_errcnt", 64'(a_err_count), 64'd0);

    // CODE_W=27 directed, including range boundaries
    send_b(19'd0, 27'h0, 1'b0, 1'b1);
    send_b(19'd514228, 27'h7FFFFFF, 1'b0, 1'b1);
    send_b(19'd514229, 27'h0, 1'b1, 1'b1);
    send_b(19'd1, 27'h1, 1'b0, 1'b1);
    send_b(19'd2, 27'h3, 1'b0, 1'b1);
    tk("b_cnt_one", 64'(b_err_count), 64'd1);
    repeat (4) @(negedge clock);

    // Backpressure with a full pipe
    @(posedge clock); #1 b_out_ready = 1'b0;
    @(negedge clock);
    send_b(19'd2, 27'h3, 1'b0, 1'b0);
    send_b(19'd1, 27'h1, 1'b0, 1'b0);
    send_b(19'd514228, 27'h7FFFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tk("bp_in_ready", 64'(b_in_ready), 64'd0);
      tk("bp_valid", 64'(b_out_valid), 64'd1);
      tk("bp_code", 64'(b_out_code), 64'h3);
      tk("bp_err", 64'(b_out_err), 64'd0);
      @(negedge clock);
    end
    @(posedge clock); #1 b_out_ready = 1'b1;
    repeat (6) @(negedge clock);

    // Clear priority over a simultaneous increment, then saturation
    b_err_clr = 1'b1;
    send_b(19'd514229, 27'h0, 1'b1, 1'b1);
    b_err_clr = 1'b0;
    tk("clr_prio", 64'(b_err_count), 64'd0);
    send_b(19'd514229, 27'h0, 1'b1, 1'b1);
    tk("cnt_inc1", 64'(b_err_count), 64'd1);
    send_b(19'd514230, 27'h0, 1'b1, 1'b1);
    send_b(19'd524287, 27'h0, 1'b1, 1'b1);
    tk("cnt_inc3", 64'(b_err_count), 64'd3);
    send_b(19'd514229, 27'h0, 1'b1, 1'b1);
    tk("cnt_sat", 64'(b_err_count), 64'd3);
    b_err_clr = 1'b1;
    @(negedge clock);
    b_err_clr = 1'b0;
    tk("clr_alone", 64'(b_err_count), 64'd0);
    repeat (5) @(negedge clock);

    // Exhaustive CODE_W=10 sweep under random backpressure
    c_rand = 1'b1;
    for (int v = 0; v < 256; v++) send_c(v[7:0]);
    c_rand = 1'b0;

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && n < 2000) begin
      @(negedge clock); n++;
    end
    tk("drain_a", 64'(qa.size()), 64'd0);
    tk("drain_b", 64'(qb.size()), 64'd0);
    tk("drain_c", 64'(qc.size()), 64'd0);
    tk("c_errcnt", 64'(c_err_count), 64'd112);

    // Asynchronous reset with words in flight
    @(negedge clock);
    b_in_data = 19'd514229; b_in_valid = 1'b1;
    @(negedge clock); b_in_data = 19'd1;
    @(negedge clock); b_in_data = 19'd2;
    @(posedge clock); #2;
    b_in_valid = 1'b0;
    tk("pre_rst_valid", 64'(b_out_valid), 64'd1);
    tk("pre_rst_cnt", 64'(b_err_count), 64'd1);
    reset_n = 1'b0;
    #1;
    tk("arst_valid", 64'(b_out_valid), 64'd0);
    tk("arst_cnt", 64'(b_err_count), 64'd0);
    tk("arst_c_cnt", 64'(c_err_count), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tk("post_rst_ready", 64'(b_in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tk("post_rst_valid", 64'(b_out_valid), 64'd0);
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
